// File: rtl/parking_gate_if.sv
// Bundle of request, sensor-tick and status signals between the parking lot
// logic and the entry-barrier controller.
interface parking_gate_if #(
  parameter int W = 8
);
  logic         req;
  logic         car_in_tick;
  logic         car_out_tick;
  logic         clr_err;
  logic         gate_open;
  logic         granted;
  logic         denied;
  logic         timeout;
  logic         full;
  logic         empty;
  logic [W-1:0] occupancy;
  logic         err;

  modport master (
    output req, car_in_tick, car_out_tick, clr_err,
    input  gate_open, granted, denied, timeout, full, empty, occupancy, err
  );

  modport slave (
    input  req, car_in_tick, car_out_tick, clr_err,
    output gate_open, granted, denied, timeout, full, empty, occupancy, err
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Entry-barrier sequencer and occupancy counter for the parking lot; grants or
// refuses entry, times the barrier and flags sensor/count inconsistencies.
module parking_gate_ctrl #(
  parameter int CAP       = 100,
  parameter int W         = 8,
  parameter int OPEN_TMO  = 50_000_000,
  parameter int CLOSE_DLY = 25_000_000,
  parameter int TMR_W     = 26
) (
  input  logic          clk,
  input  logic          reset,
  parking_gate_if.slave bus
);

  localparam logic [W-1:0]     CAP_V      = W'(CAP);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_TMO - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_DLY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             req_d_reg;
  logic             gate_open_reg;
  logic             granted_reg;
  logic             denied_reg;
  logic             timeout_reg;
  logic             full_reg;
  logic             empty_reg;
  logic             err_reg;
  logic [W-1:0]     occupancy_reg;
  logic [W-1:0]     occupancy_next;

  logic req_rise;
  logic below_cap;
  logic above_zero;
  logic in_ok;
  logic out_ok;
  logic err_set;

  always_comb begin
    req_rise       = bus.req & ~req_d_reg;
    below_cap      = (occupancy_reg < CAP_V);
    above_zero     = (occupancy_reg != '0);
    in_ok          = bus.car_in_tick & below_cap;
    out_ok         = bus.car_out_tick & above_zero;
    occupancy_next = occupancy_reg;
    if (in_ok && !out_ok) begin
      occupancy_next = occupancy_reg + W'(1);
    end else if (out_ok && !in_ok) begin
      occupancy_next = occupancy_reg - W'(1);
    end
    // Entry is only legitimate while the barrier is waiting for the granted car.
    err_set = (bus.car_in_tick & ~below_cap)
            | (bus.car_out_tick & ~above_zero)
            | (bus.car_in_tick & (state_reg != OPEN));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      req_d_reg     <= 1'b0;
      gate_open_reg <= 1'b0;
      granted_reg   <= 1'b0;
      denied_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      req_d_reg   <= bus.req;
      granted_reg <= 1'b0;
      denied_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          gate_open_reg <= 1'b0;
          if (req_rise) begin
            if (below_cap) begin
              state_reg     <= OPEN;
              granted_reg   <= 1'b1;
              gate_open_reg <= 1'b1;
              timer_reg     <= '0;
            end else begin
              denied_reg <= 1'b1;
            end
          end
        end
        OPEN: begin
          gate_open_reg <= 1'b1;
          if (bus.car_in_tick) begin
            state_reg <= CLOSE;
            timer_reg <= '0;
          end else if (timer_reg == OPEN_LAST) begin
            state_reg     <= IDLE;
            gate_open_reg <= 1'b0;
            timeout_reg   <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        CLOSE: begin
          gate_open_reg <= 1'b1;
          if (timer_reg == CLOSE_LAST) begin
            state_reg     <= IDLE;
            gate_open_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          gate_open_reg <= 1'b0;
        end
      endcase
    end
  end

  // full/empty derive from the same next value so they never disagree with the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy_reg <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      err_reg       <= 1'b0;
    end else begin
      occupancy_reg <= occupancy_next;
      full_reg      <= (occupancy_next == CAP_V);
      empty_reg     <= (occupancy_next == '0);
      if (err_set) begin
        err_reg <= 1'b1;
      end else if (bus.clr_err) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign bus.gate_open = gate_open_reg;
  assign bus.granted   = granted_reg;
  assign bus.denied    = denied_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.full      = full_reg;
  assign bus.empty     = empty_reg;
  assign bus.occupancy = occupancy_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed vector bench for parking_gate_ctrl with a small lot (CAP=3) and
// short barrier timings so every path is reachable in a few dozen cycles.
module tb_parking_gate_ctrl;

  localparam int CAP       = 3;
  localparam int W         = 8;
  localparam int OPEN_TMO  = 10;
  localparam int CLOSE_DLY = 4;
  localparam int TMR_W     = 4;

  typedef struct packed {
    logic         gate;
    logic         gnt;
    logic         den;
    logic         tmo;
    logic         full;
    logic         empty;
    logic [W-1:0] occ;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic req;
    logic cin;
    logic cout;
    logic clr;
    exp_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   applied = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  parking_gate_if #(.W(W)) bus ();

  parking_gate_ctrl #(
    .CAP(CAP), .W(W), .OPEN_TMO(OPEN_TMO), .CLOSE_DLY(CLOSE_DLY), .TMR_W(TMR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic req, input logic cin, input logic cout,
                              input logic clr, input logic gate, input logic gnt,
                              input logic den, input logic tmo, input logic full,
                              input logic empty, input int occ, input logic err);
    vec_t v;
    v.req = req; v.cin = cin; v.cout = cout; v.clr = clr;
    v.exp.gate = gate; v.exp.gnt = gnt; v.exp.den = den; v.exp.tmo = tmo;
    v.exp.full = full; v.exp.empty = empty; v.exp.occ = W'(occ); v.exp.err = err;
    return v;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.gate = bus.gate_open; a.gnt = bus.granted; a.den = bus.denied;
    a.tmo = bus.timeout; a.full = bus.full; a.empty = bus.empty;
    a.occ = bus.occupancy; a.err = bus.err;
    return a;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got gate=%b gnt=%b den=%b tmo=%b full=%b empty=%b occ=%0d err=%b, expected gate=%b gnt=%b den=%b tmo=%b full=%b empty=%b occ=%0d err=%b",
               name, act.gate, act.gnt, act.den, act.tmo, act.full, act.empty, act.occ, act.err,
               exp.gate, exp.gnt, exp.den, exp.tmo, exp.full, exp.empty, exp.occ, exp.err);
    end else begin
      $display("ok   %s: gate=%b gnt=%b den=%b tmo=%b full=%b empty=%b occ=%0d err=%b",
               name, act.gate, act.gnt, act.den, act.tmo, act.full, act.empty, act.occ, act.err);
    end
  endtask

  task automatic drive(input logic req, input logic cin, input logic cout, input logic clr);
    bus.req = req; bus.car_in_tick = cin; bus.car_out_tick = cout; bus.clr_err = clr;
  endtask

  initial begin
    int grants;
    drive(0, 0, 0, 0);

    // 1: grant, entry 3 cycles later, barrier held 4 cycles after the tick
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,0,0,0, 0,0,1,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,0));
    // 2: fill the lot, then a refused request
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,1,0));
    vecs.push_back(mk(0,1,0,0, 1,0,0,0, 0,0,2,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,2,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,2,0));
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,2,0));
    vecs.push_back(mk(0,1,0,0, 1,0,0,0, 1,0,3,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0,1,0, 1,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,0,2,0));
    // 3: grant with no car -> open for 10 cycles then timeout
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,2,0));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,2,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,2,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,2,0));
    // 4: simultaneous in/out during OPEN
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,2,0));
    vecs.push_back(mk(0,1,1,0, 1,0,0,0, 0,0,2,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,2,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,2,0));
    // 5: underflow, clear, unauthorised entries, set-beats-clear, in at full
    vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,1,0,1));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,1,0,1, 0,0,0,0, 0,0,2,1));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0, 0,0,2,0));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0, 1,0,3,1));
    vecs.push_back(mk(0,1,0,1, 0,0,0,0, 1,0,3,1));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,1,1,0, 0,0,0,0, 0,0,2,1));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0, 0,0,2,0));
    // request edge during CLOSE is dropped
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,2,0));
    vecs.push_back(mk(0,1,0,0, 1,0,0,0, 1,0,3,0));
    vecs.push_back(mk(1,0,0,0, 1,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,0,2,0));
    vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,0,1,0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", mk(0,0,0,0, 0,0,0,0, 0,1,0,0).exp);
    reset = 1'b1;

    foreach (vecs[i]) begin
      string nm;
      drive(vecs[i].req, vecs[i].cin, vecs[i].cout, vecs[i].clr);
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d req=%b in=%b out=%b clr=%b",
                     i, vecs[i].req, vecs[i].cin, vecs[i].cout, vecs[i].clr);
      check(nm, vecs[i].exp);
    end

    // 6: asynchronous reset during CLOSE with two cars inside
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_seq_grant", mk(0,0,0,0, 1,1,0,0, 0,0,1,0).exp);
    drive(0, 1, 0, 0);
    @(posedge clk); #1;
    check("rst_seq_close", mk(0,0,0,0, 1,0,0,0, 0,0,2,0).exp);
    drive(0, 0, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", mk(0,0,0,0, 0,0,0,0, 0,1,0,0).exp);
    bus.req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.granted === 1'b1) grants++;
    end
    applied++;
    if (grants != 1) begin
      miscompares++;
      $display("FAIL held_req_grants: got %0d grant pulses, expected 1", grants);
    end else begin
      $display("ok   held_req_grants: %0d grant pulse", grants);
    end
    check("after_held_req", mk(0,0,0,0, 1,0,0,0, 0,1,0,0).exp);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
